key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//   N-channel key debouncer for front-panel push-buttons. Synchronises each
//   raw key input, filters bounce with a per-channel FSM, and emits press,
//   release, long-press and auto-repeat pulses. Sits between board pins and
//   the mode/parameter control logic; channels are fully independent.
// PARAMETERS
//   N_KEYS        4           number of key channels (>=1)
//   DEB_CYCLES    1_000_000   debounce interval in clk cycles (20 ms @ 50 MHz), >=2
//   LONG_CYCLES   50_000_000  hold time in DOWN before long_pulse (1 s), >=2
//   REPEAT_CYCLES 10_000_000  auto-repeat period after long_pulse (200 ms), >=2
//   REPEAT_EN     1           1: generate repeat_pulse; 0: repeat_pulse tied 0
//   ACTIVE_LOW    1           1: key_in==0 means pressed; 0: key_in==1 means pressed
// PORTS
//   clk            in   1       system clock, all logic on rising edge
//   rst            in   1       synchronous reset, active-high
//   key_in         in   N_KEYS  raw asynchronous key levels
//   key_state      out  N_KEYS  debounced level, 1 = pressed
//   press_pulse    out  N_KEYS  1-cycle pulse on debounced press
//   release_pulse  out  N_KEYS  1-cycle pulse on debounced release
//   long_pulse     out  N_KEYS  1-cycle pulse once per press after LONG_CYCLES held
//   repeat_pulse   out  N_KEYS  1-cycle pulse every REPEAT_CYCLES after long_pulse
// BEHAVIOUR
// - Reset: all outputs 0, FSMs IDLE, all counters 0, synchroniser flops loaded
//   with the released level (ACTIVE_LOW ? 1 : 0); no spurious press after reset.
// - Per channel: 2-flop synchroniser s1->s2; p = ACTIVE_LOW ? ~s2 : s2.
// - Counters: dcnt width $clog2(DEB_CYCLES), hcnt $clog2(LONG_CYCLES),
//   rcnt $clog2(REPEAT_CYCLES); never wrap (cleared on compare).
// - FSM per channel (evaluated every edge, using current p):
//   IDLE:    p==1 -> FILTER1, dcnt<=0.
//   FILTER1: p==0 -> IDLE (bounce, no output). dcnt==DEB_CYCLES-1 -> DOWN,
//            press_pulse<=1, key_state<=1, hcnt<=0, rcnt<=0. else dcnt++.
//   DOWN:    p==0 -> FILTER2, dcnt<=0. Else if !long_done: hcnt==LONG_CYCLES-1
//            -> long_pulse<=1, long_done<=1, rcnt<=0; else hcnt++.
//            Else if long_done && REPEAT_EN: rcnt==REPEAT_CYCLES-1 ->
//            repeat_pulse<=1, rcnt<=0; else rcnt++.
//   FILTER2: p==1 -> DOWN (bounce; hcnt/rcnt/long_done retained, frozen while
//            in FILTER2). dcnt==DEB_CYCLES-1 -> IDLE, release_pulse<=1,
//            key_state<=0, long_done<=0. else dcnt++.
// - Pulses are registered and high for exactly one cycle (default 0 each edge).
// - Latency: key_in first sampled pressed at edge E0 and held -> FSM enters
//   FILTER1 at E2; press_pulse/key_state registered at E0+DEB_CYCLES+2.
//   Release symmetric: release_pulse at E0+DEB_CYCLES+2 from first released sample.
// - long_pulse at DOWN-entry edge + LONG_CYCLES; first repeat REPEAT_CYCLES
//   after long_pulse, then every REPEAT_CYCLES while in DOWN.
// - Simultaneous events: channels independent; several bits may pulse in the
//   same cycle. rst wins over every other condition.
// - Reset mid-operation: channel returns to IDLE with no release_pulse; a key
//   still held is re-detected as a new press after the full debounce.
// TESTING (N_KEYS=2, DEB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10, ACTIVE_LOW=1)
// 1. key_in[0] low from E0, high sampled at E95 -> press_pulse[0] @E10,
//    long_pulse[0] @E50, repeat_pulse[0] @E60,70,80,90, release_pulse[0] @E105;
//    key_state[0]=1 from E10 until E105.
// 2. key_in[0] low 5 cycles then high -> no pulses, key_state[0] stays 0.
// 3. Held (key_state=1), 4-cycle high glitch -> no release_pulse, key_state
//    stays 1, repeat pulses shifted later by the cycles spent in FILTER2.
// 4. key_in[1] low 20 cycles -> press_pulse[1] and release_pulse[1] only,
//    no long_pulse[1]/repeat_pulse[1].
// 5. Both keys low from same edge E0 -> press_pulse==2'b11 in the single cycle @E10.
// 6. rst for 1 cycle while key held in DOWN -> all outputs 0 next edge; key
//    still low -> press_pulse again 10 edges after first post-reset sample;
//    REPEAT_EN=0 rerun of test 1 -> long_pulse present, no repeat_pulse.

Source files
------------

// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if
//   Bundles the key levels and the debounced outputs of the key debouncer.
//   master : board side / test driver. Drives key_in and observes the outputs.
//   slave  : debouncer side. Samples key_in and drives the outputs.
// Signals (all N_KEYS wide, one bit per channel)
//   key_in         raw asynchronous key levels
//   key_state      debounced level, 1 = pressed
//   press_pulse    1-cycle pulse on debounced press
//   release_pulse  1-cycle pulse on debounced release
//   long_pulse     1-cycle pulse once per press after the long-hold time
//   repeat_pulse   1-cycle auto-repeat pulse after long_pulse
interface key_debounce_multi_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_in,
    input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  key_in,
    output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   N-channel push-button debouncer. Every channel has a 2-flop synchroniser,
//   a 4-state filter FSM (IDLE / FILTER1 / DOWN / FILTER2) and hold/repeat
//   counters, and emits registered single-cycle press, release, long-press
//   and auto-repeat pulses. Channels share nothing but the clock and reset.
// Ports
//   clk  rising-edge system clock
//   rst  synchronous reset, active high
//   bus  slave modport of key_debounce_multi_if (key_in in, all else out)
// Parameters
//   N_KEYS         channel count (>=1)
//   DEB_CYCLES     debounce interval in clk cycles (>=2)
//   LONG_CYCLES    hold time in DOWN before long_pulse (>=2)
//   REPEAT_CYCLES  auto-repeat period after long_pulse (>=2)
//   REPEAT_EN      1 enables repeat_pulse, 0 ties it low
//   ACTIVE_LOW     1: key_in==0 means pressed; 0: key_in==1 means pressed
module key_debounce_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input logic                 clk,
  input logic                 rst,
  key_debounce_multi_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);

  // Level a released key presents on the pin; the synchroniser resets to it
  // so that leaving reset never looks like a press edge.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER1 = 2'd1,
    DOWN    = 2'd2,
    FILTER2 = 2'd3
  } state_t;

  logic [N_KEYS-1:0] state_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] rel_v;
  logic [N_KEYS-1:0] long_v;
  logic [N_KEYS-1:0] rpt_v;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    logic          s1, s2;
    logic          p;
    state_t        st;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          long_done;
    logic          ks, pp, rp, lp, tp;

    // Pressed indication, polarity-normalised from the synchronised level.
    assign p = (ACTIVE_LOW != 0) ? ~s2 : s2;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1        <= REL_LVL;
        s2        <= REL_LVL;
        st        <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        rcnt      <= '0;
        long_done <= 1'b0;
        ks        <= 1'b0;
        pp        <= 1'b0;
        rp        <= 1'b0;
        lp        <= 1'b0;
        tp        <= 1'b0;
      end else begin
        s1 <= bus.key_in[i];
        s2 <= s1;
        pp <= 1'b0;
        rp <= 1'b0;
        lp <= 1'b0;
        tp <= 1'b0;
        case (st)
          IDLE: begin
            if (p) begin
              st   <= FILTER1;
              dcnt <= '0;
            end
          end
          FILTER1: begin
            if (!p) begin
              st <= IDLE;
            end else if (dcnt == DEB_LAST) begin
              st   <= DOWN;
              pp   <= 1'b1;
              ks   <= 1'b1;
              hcnt <= '0;
              rcnt <= '0;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
          DOWN: begin
            if (!p) begin
              st   <= FILTER2;
              dcnt <= '0;
            end else if (!long_done) begin
              if (hcnt == HLD_LAST) begin
                lp        <= 1'b1;
                long_done <= 1'b1;
                rcnt      <= '0;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end else if (REPEAT_EN != 0) begin
              if (rcnt == RPT_LAST) begin
                tp   <= 1'b1;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
          end
          FILTER2: begin
            // A bounce back to pressed resumes DOWN with hold/repeat timing
            // frozen, so the glitch only delays the next repeat.
            if (p) begin
              st <= DOWN;
            end else if (dcnt == DEB_LAST) begin
              st        <= IDLE;
              rp        <= 1'b1;
              ks        <= 1'b0;
              long_done <= 1'b0;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign state_v[i] = ks;
    assign press_v[i] = pp;
    assign rel_v[i]   = rp;
    assign long_v[i]  = lp;
    assign rpt_v[i]   = tp;
  end

  assign bus.key_state     = state_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = rel_v;
  assign bus.long_pulse    = long_v;
  assign bus.repeat_pulse  = rpt_v;

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi
//   Two DUTs (REPEAT_EN=1 and REPEAT_EN=0) share the same key stimulus.
//   Each scenario is a table of key/reset changes plus a table of expected
//   pulse events at given edges; every edge both DUTs' outputs are compared
//   with the expected word (key_state follows the expected press/release).
module tb_key_debounce_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.N_KEYS(2)) bus_a ();
  key_debounce_multi_if #(.N_KEYS(2)) bus_b ();

  key_debounce_multi #(
    .N_KEYS(2), .DEB_CYCLES(8), .LONG_CYCLES(40), .REPEAT_CYCLES(10),
    .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  key_debounce_multi #(
    .N_KEYS(2), .DEB_CYCLES(8), .LONG_CYCLES(40), .REPEAT_CYCLES(10),
    .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int         at;
    logic       r;
    logic [1:0] key;
  } stim_t;

  typedef struct {
    int         at;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] rpt;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic add_s(input int at, input logic r, input logic [1:0] key);
    stim_t s;
    s.at = at; s.r = r; s.key = key;
    stim_q.push_back(s);
  endtask

  task automatic add_e(input int at, input logic [1:0] prs, input logic [1:0] rel,
                       input logic [1:0] lng, input logic [1:0] rpt);
    exp_t e;
    e.at = at; e.prs = prs; e.rel = rel; e.lng = lng; e.rpt = rpt;
    exp_q.push_back(e);
  endtask

  task automatic clear_tables();
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic check(input string name, input int k, input logic [9:0] act,
                       input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got {state,press,rel,long,rpt}=%b expected %b",
               name, k, act, req);
    end
  endtask

  function automatic logic [9:0] word_a();
    return {bus_a.key_state, bus_a.press_pulse, bus_a.release_pulse,
            bus_a.long_pulse, bus_a.repeat_pulse};
  endfunction

  function automatic logic [9:0] word_b();
    return {bus_b.key_state, bus_b.press_pulse, bus_b.release_pulse,
            bus_b.long_pulse, bus_b.repeat_pulse};
  endfunction

  // Reset with keys released, then apply the stimulus table for n edges.
  task automatic run_scn(input string name, input int n);
    logic       r;
    logic [1:0] key, st, p, rl, lg, rp;
    logic [9:0] ea, eb;
    int         si;
    @(negedge clk);
    rst = 1'b1;
    bus_a.key_in = 2'b11;
    bus_b.key_in = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_rst_a"}, -1, word_a(), 10'd0);
    check({name, "_rst_b"}, -1, word_b(), 10'd0);
    @(negedge clk);
    st = 2'b00; key = 2'b11; r = 1'b0; si = 0;
    for (int k = 0; k < n; k++) begin
      while (si < stim_q.size() && stim_q[si].at <= k) begin
        key = stim_q[si].key;
        r   = stim_q[si].r;
        si++;
      end
      rst = r;
      bus_a.key_in = key;
      bus_b.key_in = key;
      @(posedge clk);
      #1;
      p = 2'b00; rl = 2'b00; lg = 2'b00; rp = 2'b00;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (exp_q[j].at == k) begin
          p  |= exp_q[j].prs;
          rl |= exp_q[j].rel;
          lg |= exp_q[j].lng;
          rp |= exp_q[j].rpt;
        end
      end
      if (r) begin
        st = 2'b00; p = 2'b00; rl = 2'b00; lg = 2'b00; rp = 2'b00;
      end else begin
        st = (st | p) & ~rl;
      end
      ea = {st, p, rl, lg, rp};
      eb = {st, p, rl, lg, 2'b00};
      check({name, "_a"}, k, word_a(), ea);
      check({name, "_b"}, k, word_b(), eb);
      @(negedge clk);
    end
  endtask

  initial begin
    bus_a.key_in = 2'b11;
    bus_b.key_in = 2'b11;

    // Long hold on key 0 with repeats, then release.
    clear_tables();
    add_s(0, 1'b0, 2'b10);
    add_s(95, 1'b0, 2'b11);
    add_e(10, 2'b01, 2'b00, 2'b00, 2'b00);
    add_e(50, 2'b00, 2'b00, 2'b01, 2'b00);
    for (int t = 60; t <= 90; t += 10) add_e(t, 2'b00, 2'b00, 2'b00, 2'b01);
    add_e(105, 2'b00, 2'b01, 2'b00, 2'b00);
    run_scn("hold", 115);

    // 5-cycle press is a bounce: nothing at all.
    clear_tables();
    add_s(0, 1'b0, 2'b10);
    add_s(5, 1'b0, 2'b11);
    run_scn("bounce", 30);

    // 4-cycle release glitch while held: repeats shift by 5 edges.
    clear_tables();
    add_s(0, 1'b0, 2'b10);
    add_s(62, 1'b0, 2'b11);
    add_s(66, 1'b0, 2'b10);
    add_s(90, 1'b0, 2'b11);
    add_e(10, 2'b01, 2'b00, 2'b00, 2'b00);
    add_e(50, 2'b00, 2'b00, 2'b01, 2'b00);
    add_e(60, 2'b00, 2'b00, 2'b00, 2'b01);
    add_e(75, 2'b00, 2'b00, 2'b00, 2'b01);
    add_e(85, 2'b00, 2'b00, 2'b00, 2'b01);
    add_e(100, 2'b00, 2'b01, 2'b00, 2'b00);
    run_scn("glitch", 110);

    // Short press on key 1: press and release only.
    clear_tables();
    add_s(0, 1'b0, 2'b01);
    add_s(20, 1'b0, 2'b11);
    add_e(10, 2'b10, 2'b00, 2'b00, 2'b00);
    add_e(30, 2'b00, 2'b10, 2'b00, 2'b00);
    run_scn("short1", 50);

    // Both keys from the same edge: simultaneous pulses.
    clear_tables();
    add_s(0, 1'b0, 2'b00);
    add_s(30, 1'b0, 2'b11);
    add_e(10, 2'b11, 2'b00, 2'b00, 2'b00);
    add_e(40, 2'b00, 2'b11, 2'b00, 2'b00);
    run_scn("both", 50);

    // Debounce boundary: 8 low samples on key 1 (rejected), 9 on key 0 (accepted).
    clear_tables();
    add_s(0, 1'b0, 2'b00);
    add_s(8, 1'b0, 2'b10);
    add_s(9, 1'b0, 2'b11);
    add_e(10, 2'b01, 2'b00, 2'b00, 2'b00);
    add_e(19, 2'b00, 2'b01, 2'b00, 2'b00);
    run_scn("deb_edge", 30);

    // Reset while held in DOWN: no release, re-detected after full debounce.
    clear_tables();
    add_s(0, 1'b0, 2'b10);
    add_s(20, 1'b1, 2'b10);
    add_s(21, 1'b0, 2'b10);
    add_e(10, 2'b01, 2'b00, 2'b00, 2'b00);
    add_e(31, 2'b01, 2'b00, 2'b00, 2'b00);
    add_e(71, 2'b00, 2'b00, 2'b01, 2'b00);
    run_scn("midrst", 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
